serial_parity_tx: RTL and testbench
===================================

SERIAL_PARITY_TX -- requirements
Module: serial_parity_tx

Interface
REQ-001 Parameter: DATA_W, default 8, width of the parallel input word (legal range 2..32).
REQ-002 Port: clk  input  1  single clock, all state updates on its rising edge.
REQ-003 Port: arstn  input  1  asynchronous active-low reset.
REQ-004 Port: din  input  DATA_W  parallel word to serialize.
REQ-005 Port: din_valid  input  1  din holds a word offered for transfer.
REQ-006 Port: din_ready  output  1  block accepts din this cycle.
REQ-007 Port: w  output  1  registered serial bit stream, LSB first, feeding the downstream bit-pattern detector.
REQ-008 Port: w_valid  output  1  w carries a frame bit this cycle.
REQ-009 Port: busy  output  1  a frame is in progress.
REQ-010 Port: frame_done  output  1  one-cycle pulse marking the last bit of a frame on w.

Function
REQ-011 Transfer SHALL occur on a rising edge where din_valid=1 and din_ready=1; din is captured into a shift register at that edge.
REQ-012 States SHALL be IDLE, DATA, PAR; IDLE->DATA on transfer; DATA->PAR after DATA_W bits when parity is enabled, else DATA->IDLE; PAR->IDLE.
REQ-013 In DATA, w SHALL present din[0] in the first cycle after transfer, then din[1] .. din[DATA_W-1] on consecutive cycles, with w_valid=1 in each.
REQ-014 A bit counter SHALL count 0..DATA_W-1 in DATA and clear on every state entry; no wrap beyond DATA_W-1.
REQ-015 In PAR, w SHALL equal the odd-parity bit (~^ of captured word), so total ones over data plus parity is odd; w_valid=1.
REQ-016 In IDLE, w=0 and w_valid=0.
REQ-017 din_ready SHALL be 1 in IDLE and in the final bit cycle of a frame (last DATA bit or PAR), 0 otherwise.
REQ-018 Transfer in the final bit cycle SHALL start the next frame in the immediately following cycle (back-to-back, no idle gap, w_valid continuously 1).
REQ-019 frame_done SHALL be 1 exactly in the cycle the final frame bit is on w, 0 otherwise.
REQ-020 busy SHALL be 1 in DATA and PAR, 0 in IDLE.
REQ-021 din and din_valid SHALL be ignored while din_ready=0; the captured word is not altered mid-frame.
REQ-022 Unreachable state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-023 arstn=0 SHALL immediately force IDLE, shift register=0, counter=0, w=0, w_valid=0, busy=0, frame_done=0, din_ready=1 (after release).
REQ-024 Reset mid-frame SHALL abort the frame without frame_done; first transfer after release starts a fresh frame.
REQ-025 Reset release SHALL take effect synchronously to the next rising edge of clk.

Configuration
REQ-026 Macro ODD_PARITY_BIT_EN defined: PAR state present, frame = DATA_W+1 bits, frame_done on the parity bit.
REQ-027 Macro ODD_PARITY_BIT_EN undefined: PAR state and parity logic removed, frame = DATA_W bits, frame_done and din_ready-final on bit DATA_W-1.

Verification
REQ-028 Macro on, din=8'hFF accepted cycle 0 -> w=1 in cycles 1..8, parity w=1 in cycle 9, frame_done=1 in cycle 9 only.
REQ-029 Macro on, din=8'h01 -> w=1,0,0,0,0,0,0,0 then parity 0; din=8'h00 -> eight 0 then parity 1.
REQ-030 Macro on, 8'hA5 then 8'h3C held valid -> 18 contiguous w_valid cycles: 1,0,1,0,0,1,0,1,1 then 0,0,1,1,1,1,0,0,1; frame_done in cycles 9 and 18.
REQ-031 arstn pulsed low while bit 4 of 8'hFF is on w -> w=0, w_valid=0, busy=0 immediately; no frame_done; next word 8'h03 transmits cleanly.
REQ-032 Macro off, din=8'hFF -> eight w=1 cycles, frame_done in cycle 8, no ninth bit, din_ready=1 in cycle 8.
REQ-033 din_valid toggled with changing din while busy -> transmitted bits match captured word only.

Source files
------------

// File: rtl/serial_parity_tx.sv
// serial_parity_tx: serializes a DATA_W-bit word LSB first onto w, with an optional odd-parity bit.
// Ports:
//   clk, arstn              clock and asynchronous active-low reset
//   din, din_valid          parallel word offered for transfer
//   din_ready               word accepted on an edge where din_valid is also high
//   w, w_valid              registered serial bit and its frame-bit qualifier
//   busy                    a frame is in progress
//   frame_done              one-cycle pulse on the last bit of a frame
// Build option: define ODD_PARITY_BIT_EN to append an odd-parity bit to each frame.
module serial_parity_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              w,
  output logic              w_valid,
  output logic              busy,
  output logic              frame_done
);
  localparam int CW = $clog2(DATA_W);
`ifdef ODD_PARITY_BIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              w_q, w_d;
  logic              xfer, data_last;
  assign data_last = (state_q == DATA) && (cnt_q == CW'(DATA_W - 1));
`ifdef ODD_PARITY_BIT_EN
  logic par_q, par_d;
  assign frame_done = (state_q == PAR);
  assign par_d      = xfer ? ~^din : par_q;
`else
  assign frame_done = data_last;
`endif
  // Every frame-bit cycle is either a DATA cycle or the final (parity) cycle.
  assign busy      = (state_q == DATA) || frame_done;
  assign w_valid   = busy;
  assign w         = w_q;
  assign din_ready = (state_q == IDLE) || frame_done;
  assign xfer      = din_valid && din_ready;
  // sh_q holds the remaining bits with the one currently on w at bit 0,
  // so the next bit to present is always sh_q[1].
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    sh_d    = xfer ? din : (state_q == DATA) ? (sh_q >> 1) : sh_q;
    w_d     = xfer ? din[0] : 1'b0;
    case (state_q)
      IDLE: state_d = xfer ? DATA : IDLE;
      DATA: begin
        if (!data_last) begin
          state_d = DATA;
          cnt_d   = cnt_q + 1'b1;
          w_d     = sh_q[1];
        end else begin
`ifdef ODD_PARITY_BIT_EN
          state_d = PAR;
          w_d     = par_q;
`else
          state_d = xfer ? DATA : IDLE;
`endif
        end
      end
`ifdef ODD_PARITY_BIT_EN
      PAR:  state_d = xfer ? DATA : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      w_q     <= 1'b0;
`ifdef ODD_PARITY_BIT_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      w_q     <= w_d;
`ifdef ODD_PARITY_BIT_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_parity_tx.sv
// tb_serial_parity_tx: directed and random stimulus checked against a bit-queue reference model.
module tb_serial_parity_tx;
  localparam int DW = 8;
`ifdef ODD_PARITY_BIT_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  localparam int FL = DW + PE;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic [DW-1:0] din = '0;
  logic din_valid = 1'b0;
  logic din_ready, w, w_valid, busy, frame_done;
  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] q[$];
  always #5 clk = ~clk;
  serial_parity_tx #(.DATA_W(DW)) dut (
    .clk(clk), .arstn(arstn), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .w(w), .w_valid(w_valid), .busy(busy), .frame_done(frame_done)
  );
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic has;
    has = q.size() > 0;
    chk("w", w, has ? q[0][0] : 1'b0);
    chk("w_valid", w_valid, has);
    chk("busy", busy, has);
    chk("frame_done", frame_done, has ? q[0][1] : 1'b0);
    chk("din_ready", din_ready, q.size() <= 1);
  endtask
  task automatic push_frame(input logic [DW-1:0] d);
    for (int i = 0; i < DW; i++) q.push_back({(PE == 0) && (i == DW - 1), d[i]});
    if (PE != 0) q.push_back({1'b1, ($countones(d) % 2) == 0});
  endtask
  task automatic cyc(input logic v, input logic [DW-1:0] d);
    logic x;
    din_valid = v;
    din = d;
    x = v && (q.size() <= 1);
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (x) push_frame(d);
    #1;
    check_all();
  endtask
  task automatic drain();
    repeat (FL + 1) cyc(1'b0, DW'($urandom));
  endtask
  initial begin
    @(posedge clk);
    #1;
    check_all();
    arstn = 1'b1;
    cyc(1'b0, '0);
    cyc(1'b1, 8'hFF);
    drain();
    cyc(1'b1, 8'h01);
    drain();
    cyc(1'b1, 8'h00);
    drain();
    cyc(1'b1, 8'hA5);
    repeat (FL) cyc(1'b1, 8'h3C);
    drain();
    cyc(1'b1, 8'hFF);
    repeat (4) cyc(1'b0, '0);
    #1;
    arstn = 1'b0;
    #1;
    q.delete();
    chk("rst_w", w, 1'b0);
    chk("rst_w_valid", w_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    #1;
    arstn = 1'b1;
    cyc(1'b0, '0);
    cyc(1'b1, 8'h03);
    drain();
    cyc(1'b1, 8'h5A);
    repeat (FL - 1) cyc(1'($urandom), DW'($urandom));
    drain();
    repeat (400) cyc($urandom_range(0, 3) != 0, DW'($urandom));
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
